prio_preempt_arbiter: RTL

- Parametrised N-master bus arbiter, successor to the fixed 3-master arbiter.
- Master 0 has priority: it gets indefinite ownership from idle, and time-bounded preemption of any other owner.
- Masters 1..N-1 share the bus round-robin with a bounded time slice; a preempted master resumes its remaining slice.
- Sits between master request/done pulses and the shared-resource mux; exports grant id, one-hot state and an interrupt counter for checkers.

---
 rtl/prio_arb_pkg.sv | 33 +++
 rtl/prio_preempt_arbiter_rr_pick.sv | 31 +++
 rtl/prio_preempt_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: shared types and helpers for the priority/preemptive arbiter.
//   arb_state_t  - arbiter state encoding (also the bit index into mstate)
//   MS_*         - one-hot bit positions of mstate
//   id_width     - width of a grant id able to encode "none" plus n masters
//   idx_width    - width of an index over 0..n-1 (at least one bit)
//   grant_encode - master index -> grant id (index+1), 0 when no owner
package prio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_HP  = 2'd1,
        ST_OWN_LP  = 2'd2,
        ST_PREEMPT = 2'd3
    } arb_state_t;

    localparam int unsigned MS_IDLE    = 0;
    localparam int unsigned MS_OWN_HP  = 1;
    localparam int unsigned MS_OWN_LP  = 2;
    localparam int unsigned MS_PREEMPT = 3;

    function automatic int unsigned id_width(input int unsigned n_masters);
        return $clog2(n_masters + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned grant_encode(input logic valid, input int unsigned idx);
        return valid ? idx + 1 : 0;
    endfunction

endpackage

// File: rtl/prio_preempt_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   pend  - pending bits of the round-robin masters (bit j = master j+1)
//   ptr   - position at which the search starts
//   valid - some bit of pend is set
//   idx   - first set position found searching cyclically from ptr
module rr_pick #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [WIDTH-1:0] pend,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            int unsigned      pos;
            logic [WIDTH-1:0] sh;
            pos = (32'(ptr) + k) % WIDTH;
            sh  = pend >> pos;
            if (!valid && sh[0]) begin
                valid = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/prio_preempt_arbiter.sv
// prio_preempt_arbiter: N-master bus arbiter. Master 0 owns indefinitely from
// idle and can preempt a round-robin owner for a bounded time; masters 1..N-1
// share the bus round-robin with a bounded slice, and a preempted owner
// resumes its remaining slice.
//   clk, reset    - clock, synchronous active-high reset
//   req, done     - one-cycle request / release pulses, one bit per master
//   grant_id      - 0 = no owner, k = master k-1
//   grant_oh      - one-hot owner (all zero when none)
//   mstate        - one-hot {PREEMPT, OWN_LP, OWN_HP, IDLE}
//   nb_interrupts - saturating count of preemptions
module prio_preempt_arbiter
    import prio_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS   = 3,
    parameter int unsigned SLICE       = 2,
    parameter int unsigned PREEMPT_MAX = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_MASTERS-1:0]           req,
    input  logic [N_MASTERS-1:0]           done,
    output logic [$clog2(N_MASTERS+1)-1:0] grant_id,
    output logic [N_MASTERS-1:0]           grant_oh,
    output logic [3:0]                     mstate,
    output logic [CNT_W-1:0]               nb_interrupts
);

    localparam int unsigned ID_W  = id_width(N_MASTERS);
    localparam int unsigned IDX_W = idx_width(N_MASTERS);
    localparam int unsigned LP_N  = N_MASTERS - 1;
    localparam int unsigned SL_W  = idx_width(SLICE);
    localparam int unsigned PC_W  = idx_width(PREEMPT_MAX);

    arb_state_t           state, nxt_state;
    logic [IDX_W-1:0]     owner, nxt_owner;
    logic [IDX_W-1:0]     saved_owner, nxt_saved_owner;
    logic [SL_W-1:0]      slice_cnt, nxt_slice;
    logic [SL_W-1:0]      saved_slice, nxt_saved_slice;
    logic [PC_W-1:0]      preempt_cnt, nxt_pc;
    logic [IDX_W-1:0]     rr_ptr, nxt_ptr;
    logic [CNT_W-1:0]     nb_cnt, nxt_nb;
    logic [N_MASTERS-1:0] pending, pend_upd;

    logic [N_MASTERS-1:0] owner_oh;
    logic [N_MASTERS-1:0] req_eff;
    logic [N_MASTERS-1:0] arb_pend;
    logic [N_MASTERS-1:0] grant_mask;
    logic                 own_lp, done_own, release_lp;
    logic                 do_arb, grant_now;
    logic                 lp_valid;
    logic [IDX_W-1:0]     lp_idx;

    for (genvar g = 0; g < N_MASTERS; g++) begin : g_oh
        assign owner_oh[g]   = (state != ST_IDLE) && (owner == IDX_W'(g));
        assign grant_mask[g] = grant_now && (nxt_owner == IDX_W'(g));
    end

    assign own_lp     = (state == ST_OWN_LP);
    assign done_own   = |(done & owner_oh);
    assign release_lp = own_lp && (done_own || (slice_cnt == '0));

    // The owner's own req is dropped unless it arrives with its done (that
    // illegal pair still records the request). Master 0's req means nothing
    // while it already holds the bus.
    always_comb begin
        req_eff = req & ~(owner_oh & ~done);
        if (state == ST_OWN_HP || state == ST_PREEMPT) begin
            req_eff[0] = 1'b0;
        end
    end

    // A releasing owner is never re-granted at its own release edge.
    assign arb_pend = (pending | req_eff) & ~owner_oh;

    rr_pick #(
        .WIDTH (LP_N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .pend  (arb_pend[N_MASTERS-1:1]),
        .ptr   (rr_ptr),
        .valid (lp_valid),
        .idx   (lp_idx)
    );

    always_comb begin
        nxt_state       = state;
        nxt_owner       = owner;
        nxt_saved_owner = saved_owner;
        nxt_slice       = slice_cnt;
        nxt_saved_slice = saved_slice;
        nxt_pc          = preempt_cnt;
        nxt_ptr         = rr_ptr;
        nxt_nb          = nb_cnt;
        pend_upd        = pending | req_eff;
        do_arb          = 1'b0;
        grant_now       = 1'b0;

        unique case (state)
            ST_IDLE: do_arb = 1'b1;
            ST_OWN_HP: do_arb = done[0];
            ST_OWN_LP: begin
                if (release_lp) begin
                    do_arb = 1'b1;
                end else if (req[0]) begin
                    // The current cycle was an owned cycle, so the slice
                    // resumed later is the already-decremented count.
                    nxt_state       = ST_PREEMPT;
                    nxt_saved_owner = owner;
                    nxt_saved_slice = slice_cnt - 1'b1;
                    nxt_owner       = '0;
                    nxt_pc          = PC_W'(PREEMPT_MAX - 1);
                    pend_upd[0]     = pending[0];
                    if (nb_cnt != '1) begin
                        nxt_nb = nb_cnt + 1'b1;
                    end
                end else begin
                    nxt_slice = slice_cnt - 1'b1;
                end
            end
            ST_PREEMPT: begin
                if (done[0] || preempt_cnt == '0) begin
                    nxt_state = ST_OWN_LP;
                    nxt_owner = saved_owner;
                    nxt_slice = saved_slice;
                end else begin
                    nxt_pc = preempt_cnt - 1'b1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase

        if (do_arb) begin
            if (arb_pend[0]) begin
                grant_now = 1'b1;
                nxt_state = ST_OWN_HP;
                nxt_owner = '0;
            end else if (lp_valid) begin
                grant_now = 1'b1;
                nxt_state = ST_OWN_LP;
                nxt_owner = lp_idx + 1'b1;
                nxt_slice = SL_W'(SLICE - 1);
                nxt_ptr   = (lp_idx == IDX_W'(LP_N - 1)) ? '0 : lp_idx + 1'b1;
            end else begin
                nxt_state = ST_IDLE;
                nxt_owner = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= '0;
            saved_owner <= '0;
            slice_cnt   <= '0;
            saved_slice <= '0;
            preempt_cnt <= '0;
            rr_ptr      <= '0;
            nb_cnt      <= '0;
            pending     <= '0;
        end else begin
            state       <= nxt_state;
            owner       <= nxt_owner;
            saved_owner <= nxt_saved_owner;
            slice_cnt   <= nxt_slice;
            saved_slice <= nxt_saved_slice;
            preempt_cnt <= nxt_pc;
            rr_ptr      <= nxt_ptr;
            nb_cnt      <= nxt_nb;
            pending     <= pend_upd & ~grant_mask;
        end
    end

    assign grant_id      = ID_W'(grant_encode(state != ST_IDLE, 32'(owner)));
    assign grant_oh      = owner_oh;
    assign nb_interrupts = nb_cnt;

    always_comb begin
        mstate             = '0;
        mstate[MS_IDLE]    = (state == ST_IDLE);
        mstate[MS_OWN_HP]  = (state == ST_OWN_HP);
        mstate[MS_OWN_LP]  = (state == ST_OWN_LP);
        mstate[MS_PREEMPT] = (state == ST_PREEMPT);
    end

endmodule
